// File: rtl/lpc_pkg.sv
// Shared LPC cycle-word layout and helpers for the cycle logger.
package lpc_pkg;

    localparam int unsigned CYC_W    = 32;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_LSB = 8;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MEM_BIT  = 1;
    localparam int unsigned WR_BIT   = 0;
    localparam int unsigned TS_W     = 16;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef logic [ADDR_W-1:0] lpc_addr_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [5:0]        rsvd;
        logic              mem;
        logic              wr;
    } lpc_cyc_t;

    function automatic lpc_addr_t cyc_addr(input logic [CYC_W-1:0] w);
        return w[ADDR_LSB +: ADDR_W];
    endfunction

    function automatic logic addr_in_window(
        input lpc_addr_t a,
        input lpc_addr_t lo,
        input lpc_addr_t hi
    );
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/lpc_sync_fifo.sv
// Synchronous FIFO with level count; pointers wrap modulo DEPTH.
module lpc_sync_fifo
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    logic do_push;
    logic do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when a pop frees a slot.
    assign do_pop  = pop_i & ~empty_o & ~rst_i;
    assign do_push = push_i & (~full_o | do_pop) & ~rst_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lpc_cycle_logger.sv
// LPC cycle logger: edge capture, address filter, FIFO, drop counters.
// Define LPC_CYCLE_TIMESTAMP_EN to add a per-entry 16-bit timestamp (m_ts_o).
module lpc_cycle_logger
    import lpc_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter logic [15:0] ADDR_LO = 16'h0080,
    parameter logic [15:0] ADDR_HI = 16'h0080
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [31:0]                cyc_data_i,
    input  logic                       cyc_ready_i,
    output logic [31:0]                m_data_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_cnt_o,
`ifdef LPC_CYCLE_TIMESTAMP_EN
    output logic [TS_W-1:0]            m_ts_o,
`endif
    input  logic                       clear_i
);

`ifdef LPC_CYCLE_TIMESTAMP_EN
    localparam int unsigned FW = CYC_W + TS_W;
`else
    localparam int unsigned FW = CYC_W;
`endif

    logic        ready_q, ready_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic          capture;
    logic          hit;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    logic [FW-1:0] fifo_wdata;
    logic [FW-1:0] fifo_rdata;

    assign capture = cyc_ready_i & ~ready_q & ~rst_i;
    assign hit     = addr_in_window(cyc_addr(cyc_data_i), ADDR_LO, ADDR_HI);
    assign push    = capture & hit;
    assign pop     = m_valid_o & m_ready_i;
    assign drop    = push & full & ~pop;

`ifdef LPC_CYCLE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d       = ts_q + 1'b1;
    assign fifo_wdata = {ts_q, cyc_data_i};
    assign m_ts_o     = empty ? '0 : fifo_rdata[CYC_W +: TS_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    assign fifo_wdata = cyc_data_i;
`endif

    lpc_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    // Storage is not reset, so the head word is masked while empty.
    assign m_valid_o  = ~empty;
    assign m_data_o   = empty ? '0 : fifo_rdata[CYC_W-1:0];
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

    always_comb begin
        ready_d    = cyc_ready_i;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_lpc_cycle_logger.sv
// Bench for lpc_cycle_logger: vector table, directed corners, random vs queue model.
module tb_lpc_cycle_logger;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cyc_data;
    logic        cyc_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clear;
`ifdef LPC_CYCLE_TIMESTAMP_EN
    logic [15:0] m_ts;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    lpc_cycle_logger dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cyc_data_i  (cyc_data),
        .cyc_ready_i (cyc_ready),
        .m_data_o    (m_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .level_o     (level),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt),
`ifdef LPC_CYCLE_TIMESTAMP_EN
        .m_ts_o      (m_ts),
`endif
        .clear_i     (clear)
    );

    typedef struct {
        logic [31:0] data;
        logic        rdy;
        logic        mr;
        logic        clr;
        int          lvl;
        logic        vld;
        logic [31:0] dat;
        logic        ovf;
        int          drp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int lvl,
                               input logic vld, input logic [31:0] dat,
                               input logic ovf, input int drp);
        chk({tag, " level"}, 32'(level), 32'(lvl));
        chk({tag, " valid"}, 32'(m_valid), 32'(vld));
        chk({tag, " data"}, m_data, dat);
        chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
        chk({tag, " drops"}, 32'(drop_cnt), 32'(drp));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cyc_ready = 1'b0;
        cyc_data  = '0;
        m_ready   = 1'b0;
        clear     = 1'b0;
        step();
        step();
        check_state("reset", 0, 1'b0, 32'h0, 1'b0, 0);
        rst = 1'b0;
    endtask

    task automatic cap(input logic [31:0] w);
        cyc_data  = w;
        cyc_ready = 1'b1;
        step();
        cyc_ready = 1'b0;
        step();
    endtask

    function automatic logic [31:0] nth(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {16'h0080, b, 8'h01};
    endfunction

    // Random-phase reference model state
    logic [31:0] mq[$];
    logic        m_prev;
    logic        m_ovf;
    int          m_drop;

    initial begin
        tbl[0]  = '{32'h00805A01, 1, 0, 0, 1, 1, 32'h00805A01, 0, 0};
        tbl[1]  = '{32'h00805A01, 1, 0, 0, 1, 1, 32'h00805A01, 0, 0};
        tbl[2]  = '{32'h00805A01, 1, 0, 0, 1, 1, 32'h00805A01, 0, 0};
        tbl[3]  = '{32'h00805A01, 0, 0, 0, 1, 1, 32'h00805A01, 0, 0};
        tbl[4]  = '{32'h00815A01, 1, 0, 0, 1, 1, 32'h00805A01, 0, 0};
        tbl[5]  = '{32'h00815A01, 0, 1, 0, 0, 0, 32'h00000000, 0, 0};
        tbl[6]  = '{32'h00810000, 1, 0, 0, 0, 0, 32'h00000000, 0, 0};
        tbl[7]  = '{32'h00810000, 0, 0, 0, 0, 0, 32'h00000000, 0, 0};
        tbl[8]  = '{32'h007F1234, 1, 0, 0, 0, 0, 32'h00000000, 0, 0};
        tbl[9]  = '{32'h007F1234, 0, 0, 0, 0, 0, 32'h00000000, 0, 0};
        tbl[10] = '{32'h00801234, 1, 1, 0, 1, 1, 32'h00801234, 0, 0};
        tbl[11] = '{32'h00801234, 0, 1, 0, 0, 0, 32'h00000000, 0, 0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc_data  = tbl[i].data;
            cyc_ready = tbl[i].rdy;
            m_ready   = tbl[i].mr;
            clear     = tbl[i].clr;
            step();
            check_state($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].vld,
                        tbl[i].dat, tbl[i].ovf, tbl[i].drp);
        end
        m_ready = 1'b0;

        // Overflow on the 17th capture, then push+pop while full
        do_reset();
        for (int i = 1; i <= 17; i++) cap(nth(i));
        check_state("ovf", 16, 1'b1, nth(1), 1'b1, 1);
        cyc_data  = 32'h00809901;
        cyc_ready = 1'b1;
        m_ready   = 1'b1;
        step();
        chk("full pushpop level", 32'(level), 32'd16);
        chk("full pushpop drops", 32'(drop_cnt), 32'd1);
        cyc_ready = 1'b0;
        m_ready   = 1'b0;
        step();
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d", k), m_data,
                (k < 15) ? nth(k + 2) : 32'h00809901);
            step();
        end
        m_ready = 1'b0;
        chk("drained level", 32'(level), 32'd0);

        // Clear wins over a same-cycle drop
        do_reset();
        for (int i = 1; i <= 17; i++) cap(nth(i));
        chk("pre-clear drops", 32'(drop_cnt), 32'd1);
        cyc_data  = 32'h00804401;
        cyc_ready = 1'b1;
        clear     = 1'b1;
        step();
        chk("clear ovf", 32'(overflow), 32'd0);
        chk("clear drops", 32'(drop_cnt), 32'd0);
        chk("clear level", 32'(level), 32'd16);
        cyc_ready = 1'b0;
        clear     = 1'b0;
        step();

        // Reset mid-operation discards entries and ignores edges in reset
        do_reset();
        for (int i = 1; i <= 5; i++) cap(nth(i));
        chk("five level", 32'(level), 32'd5);
        rst       = 1'b1;
        cyc_data  = 32'h00807701;
        cyc_ready = 1'b1;
        step();
        check_state("midrst", 0, 1'b0, 32'h0, 1'b0, 0);
        rst       = 1'b0;
        cyc_ready = 1'b0;
        step();
        chk("postrst level", 32'(level), 32'd0);
        cap(32'h00803301);
        check_state("postrst cap", 1, 1'b1, 32'h00803301, 1'b0, 0);

        // Randomized run against a queue model
        do_reset();
        mq.delete();
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] a;
            logic [31:0] w;
            logic        cap_m, pop_m, full0, dropped;
            int          sel;
            sel = int'($urandom_range(0, 5));
            a = (sel == 0) ? 16'h007F :
                (sel == 1) ? 16'h0081 :
                (sel == 5) ? 16'($urandom) : 16'h0080;
            w = {a, 16'($urandom)};
            rst       = ($urandom_range(0, 299) == 0);
            cyc_data  = w;
            cyc_ready = 1'($urandom);
            m_ready   = ($urandom_range(0, 3) == 0);
            clear     = ($urandom_range(0, 63) == 0);
            if (rst) begin
                mq.delete();
                m_prev = 1'b0;
                m_ovf  = 1'b0;
                m_drop = 0;
            end else begin
                cap_m   = cyc_ready && !m_prev;
                m_prev  = cyc_ready;
                pop_m   = (mq.size() > 0) && m_ready;
                full0   = (mq.size() == DEPTH);
                dropped = 1'b0;
                if (pop_m) void'(mq.pop_front());
                if (cap_m && a >= 16'h0080 && a <= 16'h0080) begin
                    if (!full0 || pop_m) mq.push_back(w);
                    else dropped = 1'b1;
                end
                if (clear) begin
                    m_ovf  = 1'b0;
                    m_drop = 0;
                end else if (dropped) begin
                    m_ovf = 1'b1;
                    if (m_drop != 65535) m_drop++;
                end
            end
            step();
            check_state($sformatf("rnd%0d", c), mq.size(), mq.size() > 0,
                        (mq.size() > 0) ? mq[0] : 32'h0, m_ovf, m_drop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
